peripheral_adder_arbiter: RTL and testbench

//  Shares one external registered adder (fixed ADDER_LAT-cycle latency, no stall) between NUM_REQ requesters.

---
 rtl/peripheral_adder_arbiter_pkg.sv | 19 +
 rtl/peripheral_rr_arbiter.sv | 35 +++
 rtl/peripheral_adder_arbiter.sv | 77 +++++++
 tb/tb_peripheral_adder_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/peripheral_adder_arbiter_pkg.sv
// peripheral_adder_arbiter_pkg: shared defaults, id-width helper and response/tag types
package peripheral_adder_arbiter_pkg;
  function automatic int calc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDER_LAT = 1;
  localparam int DEF_RSP_DEPTH = 4;
  localparam int DEF_ID_W = calc_id_w(DEF_NUM_REQ);
  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic [DEF_DATA_W:0] data;
  } rsp_t;
  typedef struct packed {
    logic valid;
    logic [DEF_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/peripheral_rr_arbiter.sv
// peripheral_rr_arbiter: round-robin one-hot grant; pointer moves past the winner on accept
module peripheral_rr_arbiter
  import peripheral_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W = calc_id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  input  logic               i_acc,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx
);
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;
  logic            w_hit;
  always_comb begin
    w_hit = 1'b0;
    w_cand = '0;
    o_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_hit && i_req[w_cand]) begin
        w_hit = 1'b1;
        o_idx = w_cand;
      end
    end
    o_gnt = (w_hit && i_en) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << o_idx : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (i_acc) r_ptr <= (o_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/peripheral_adder_arbiter.sv
// peripheral_adder_arbiter: shares one fixed-latency adder among requesters with credit-limited issue
module peripheral_adder_arbiter
  import peripheral_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDER_LAT = DEF_ADDER_LAT,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH,
  localparam int ID_W = calc_id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  output logic                      add_issue,
  output logic [DATA_W-1:0]         add_in1,
  output logic [DATA_W-1:0]         add_in2,
  input  logic [DATA_W:0]           add_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W:0]           rsp_data,
  output logic                      busy
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = calc_id_w(RSP_DEPTH);
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  logic [CW-1:0]   r_credit, r_cnt;
  logic [PW-1:0]   r_wp, r_rp;
  tag_t            r_tag [ADDER_LAT];
  rsp_t            r_mem [RSP_DEPTH];
  logic [ID_W-1:0] w_idx;
  logic            w_acc, w_push, w_pop;
  peripheral_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (req_valid),
    .i_en  (r_credit < CW'(RSP_DEPTH)),
    .i_acc (w_acc),
    .o_gnt (req_ready),
    .o_idx (w_idx)
  );
  assign w_acc = |(req_valid & req_ready);
  assign add_issue = w_acc;
  assign add_in1 = w_acc ? req_in1[w_idx*DATA_W +: DATA_W] : '0;
  assign add_in2 = w_acc ? req_in2[w_idx*DATA_W +: DATA_W] : '0;
  assign w_push = r_tag[ADDER_LAT-1].valid;
  assign w_pop = rsp_valid && rsp_ready;
  assign rsp_valid = r_cnt != '0;
  assign rsp_id = rsp_valid ? r_mem[r_rp].id : '0;
  assign rsp_data = rsp_valid ? r_mem[r_rp].data : '0;
  assign busy = r_credit != '0;
  // Credit covers both in-flight tags and buffered responses, so a push never meets a full FIFO.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tag <= '{default: '0};
      r_credit <= '0;
      r_cnt <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_tag[0] <= '{valid: w_acc, id: w_idx};
      for (int s = 1; s < ADDER_LAT; s++) r_tag[s] <= r_tag[s-1];
      r_credit <= r_credit + CW'(w_acc) - CW'(w_pop);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wp <= bump(r_wp);
      if (w_pop) r_rp <= bump(r_rp);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= '{id: r_tag[ADDER_LAT-1].id, data: add_out};
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && r_cnt == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_peripheral_adder_arbiter.sv
// tb_peripheral_adder_arbiter: directed checks of grant order, latency, credit limit and reset flush
module tb_peripheral_adder_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_in1, req_in2;
  logic           add_issue;
  logic [W-1:0]   add_in1, add_in2;
  logic [W:0]     add_out;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W:0]     rsp_data;
  logic           busy;
  int             n_tests = 0;
  int             n_fail = 0;
  logic [W:0]     exp_sum [N] = '{9'h003, 9'h014, 9'h025, 9'h036};
  peripheral_adder_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .add_issue (add_issue),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .add_out   (add_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) add_out <= {1'b0, add_in1} + {1'b0, add_in2};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in1[i*W +: W] = a;
    req_in2[i*W +: W] = b;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_in1 = '0;
    req_in2 = '0;
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_issue", 32'(add_issue), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    // 1: single request latency and sum
    do_reset;
    lane(0, 8'h12, 8'h34);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("t1_grant", 32'(req_ready), 1);
    chk("t1_issue", 32'(add_issue), 1);
    chk("t1_in1", 32'(add_in1), 32'h12);
    chk("t1_in2", 32'(add_in2), 32'h34);
    tick;
    req_valid = '0;
    #1;
    chk("t1_early", 32'(rsp_valid), 0);
    tick;
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_data", 32'(rsp_data), 32'h046);
    chk("t1_busy", 32'(busy), 1);
    tick;
    chk("t1_drained", 32'(rsp_valid), 0);
    chk("t1_idle", 32'(busy), 0);
    // 2: all requesting, full throughput
    do_reset;
    for (int i = 0; i < N; i++) lane(i, 8'(i * 16 + 1), 8'(i + 2));
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 4'hF : 4'h0;
      #1;
      if (k < 6) chk($sformatf("t2_gnt%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk($sformatf("t2_valid%0d", k), 32'(rsp_valid), 1);
        chk($sformatf("t2_id%0d", k), 32'(rsp_id), 32'((k - 2) % 4));
        chk($sformatf("t2_data%0d", k), 32'(rsp_data), 32'(exp_sum[(k - 2) % 4]));
      end
      tick;
    end
    // 3: carry preserved and zero sum
    do_reset;
    lane(0, 8'hFF, 8'hFF);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("t3_issue0", 32'(add_issue), 1);
    tick;
    lane(0, 8'h00, 8'h00);
    #1;
    chk("t3_wrap_gnt", 32'(req_ready), 1);
    tick;
    req_valid = '0;
    #1;
    chk("t3_max", 32'(rsp_data), 32'h1FE);
    tick;
    chk("t3_zero_valid", 32'(rsp_valid), 1);
    chk("t3_zero", 32'(rsp_data), 32'h000);
    // 4: credit limit then drain in issue order
    do_reset;
    for (int i = 0; i < N; i++) lane(i, 8'(i * 16 + 1), 8'(i + 2));
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t4_gnt%0d", k), 32'(req_ready), (k < 4) ? 32'(1 << k) : 0);
      tick;
    end
    #1;
    chk("t4_busy", 32'(busy), 1);
    chk("t4_full_valid", 32'(rsp_valid), 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t4_id%0d", k), 32'(rsp_id), 32'(k));
      chk($sformatf("t4_data%0d", k), 32'(rsp_data), 32'(exp_sum[k]));
      tick;
    end
    chk("t4_empty", 32'(rsp_valid), 0);
    chk("t4_idle", 32'(busy), 0);
    // 5: one pop at full credit frees exactly one grant, next cycle
    do_reset;
    req_valid = 4'hF;
    repeat (5) tick;
    chk("t5_blocked", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    #1;
    chk("t5_same", 32'(req_ready), 0);
    chk("t5_head", 32'(rsp_id), 0);
    tick;
    rsp_ready = 1'b0;
    #1;
    chk("t5_next", 32'(req_ready), 1);
    chk("t5_issue", 32'(add_issue), 1);
    tick;
    chk("t5_after", 32'(req_ready), 0);
    chk("t5_busy", 32'(busy), 1);
    // 6: reset with ops in flight drops them
    do_reset;
    lane(0, 8'h01, 8'h02);
    req_valid = 4'b0001;
    tick;
    tick;
    req_valid = '0;
    #1;
    chk("t6_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t6_stale%0d", k), 32'(rsp_valid), 0);
      chk($sformatf("t6_idle%0d", k), 32'(busy), 0);
      tick;
    end
    lane(0, 8'h20, 8'h05);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("t6_issue", 32'(add_issue), 1);
    tick;
    req_valid = '0;
    tick;
    chk("t6_valid", 32'(rsp_valid), 1);
    chk("t6_id", 32'(rsp_id), 0);
    chk("t6_data", 32'(rsp_data), 32'h025);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
